// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one uart_tx between N_REQ byte streams.
// Optionally prefixes each granted packet with a header byte carrying the channel ID.
module uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int BITS_N = 8,
   parameter bit HDR_EN = 1'b1,
   parameter logic [BITS_N-1:0] HDR_BASE = BITS_N'(8'hA0),
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ*BITS_N-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic [BITS_N-1:0]         tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      busy,
   output logic [ID_W-1:0]           grant_id
);

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      PAYLOAD
   } state_t;

   state_t state;
   state_t state_nx;
   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] pick;
   logic            any_valid;
   logic            tx_xfer;
   logic            grant_last;

   assign any_valid  = |req_valid;
   assign tx_xfer    = tx_valid && tx_ready;
   assign grant_last = req_last[grant];
   assign busy       = (state != IDLE);
   assign grant_id   = grant;

   // Search starts just past the last completed grant so it rotates fairly.
   always_comb begin
      int idx;
      logic found;
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= ID_W'(N_REQ - 1);
      end else begin
         state <= state_nx;
         if (state == IDLE && any_valid) grant <= pick;
         if (state == PAYLOAD && tx_xfer && grant_last) last_grant <= grant;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (any_valid) state_nx = HDR_EN ? HEADER : PAYLOAD;
         end
         HEADER: begin
            if (tx_xfer) state_nx = PAYLOAD;
         end
         PAYLOAD: begin
            if (tx_xfer && grant_last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Payload bytes pass straight through; only tx_ready feeds req_ready.
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      req_ready = '0;
      unique case (state)
         IDLE: begin
            tx_valid = 1'b0;
         end
         HEADER: begin
            tx_valid = 1'b1;
            tx_data  = HDR_BASE | BITS_N'(grant);
         end
         PAYLOAD: begin
            tx_valid         = req_valid[grant];
            tx_data          = req_data[int'(grant)*BITS_N +: BITS_N];
            req_ready[grant] = tx_ready;
         end
         default: tx_valid = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a uart_tx
// ready model surround the header instance; a second instance runs without header.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   tx_data;
   logic           tx_valid;
   logic           tx_ready = 1'b1;
   logic           busy;
   logic [1:0]     grant_id;

   logic [N*W-1:0] r2_data = '0;
   logic [N-1:0]   r2_valid = '0;
   logic [N-1:0]   r2_last = '0;
   logic [N-1:0]   r2_ready;
   logic [W-1:0]   t2_data;
   logic           t2_valid;
   logic           t2_ready = 1'b0;
   logic           busy2;
   logic [1:0]     gid2;

   int n_chk = 0;
   int n_fail = 0;
   int frames2 = 0;
   int gap = 0;
   logic [W-1:0] frames [$];
   logic [W:0]   q [N][$];
   bit           stall [N];

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ(N), .BITS_N(W), .HDR_EN(1'b1), .HDR_BASE(8'hA0)
   ) u_dut (
      .clk(clk), .reset(reset),
      .req_data(req_data), .req_valid(req_valid),
      .req_last(req_last), .req_ready(req_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .grant_id(grant_id)
   );

   uart_tx_arbiter #(
      .N_REQ(N), .BITS_N(W), .HDR_EN(1'b0), .HDR_BASE(8'hA0)
   ) u_nohdr (
      .clk(clk), .reset(reset),
      .req_data(r2_data), .req_valid(r2_valid),
      .req_last(r2_last), .req_ready(r2_ready),
      .tx_data(t2_data), .tx_valid(t2_valid), .tx_ready(t2_ready),
      .busy(busy2), .grant_id(gid2)
   );

   // uart_tx stand-in plus requester channels fed from per-channel queues
   always @(posedge clk) begin
      if (tx_valid && tx_ready) begin
         frames.push_back(tx_data);
         tx_ready <= 1'b0;
         gap <= 2;
      end else if (gap != 0) begin
         gap <= gap - 1;
      end else begin
         tx_ready <= 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && req_ready[i] && q[i].size() > 0)
            void'(q[i].pop_front());
         if (q[i].size() > 0) begin
            req_valid[i] <= !stall[i];
            req_data[i*W +: W] <= q[i][0][W-1:0];
            req_last[i] <= q[i][0][W];
         end else begin
            req_valid[i] <= 1'b0;
            req_last[i] <= 1'b0;
         end
      end
      if (t2_valid && t2_ready) frames2 = frames2 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frames(input int n, input int budget,
                              input string tag);
      int c;
      c = 0;
      while (frames.size() < n && c < budget) begin
         tick();
         c++;
      end
      chk(tag, 32'(frames.size() >= n), 32'd1);
   endtask

   task automatic chk_frames(input string tag, input logic [W-1:0] exp [$]);
      for (int i = 0; i < exp.size(); i++) begin
         if (i < frames.size())
            chk($sformatf("%s[%0d]", tag, i), 32'(frames[i]), 32'(exp[i]));
         else
            chk($sformatf("%s[%0d] missing", tag, i), 32'd0, 32'd1);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         stall[i] = 1'b0;
      end
      tick();
      tick();
      reset = 1'b0;
      frames.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "timeout");
   end

   initial begin
      int bad;
      #1;
      do_reset();
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst tx_valid", 32'(tx_valid), 32'd0);
      chk("rst tx_data", 32'(tx_data), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst grant_id", 32'(grant_id), 32'd0);

      // 1) single 3-byte packet on ch0
      q[0].push_back({1'b0, 8'h11});
      q[0].push_back({1'b0, 8'h22});
      q[0].push_back({1'b1, 8'h33});
      wait_frames(4, 200, "t1 wait");
      chk_frames("t1 frame", '{8'hA0, 8'h11, 8'h22, 8'h33});
      chk("t1 busy after last", 32'(busy), 32'd0);

      // 2) ch1 and ch3 together after reset
      do_reset();
      q[1].push_back({1'b0, 8'h41});
      q[1].push_back({1'b1, 8'h42});
      q[3].push_back({1'b1, 8'h61});
      wait_frames(5, 300, "t2 wait");
      chk_frames("t2 frame", '{8'hA1, 8'h41, 8'h42, 8'hA3, 8'h61});
      chk("t2 grant_id", 32'(grant_id), 32'd3);

      // 3) all channels with two pending 1-byte packets
      do_reset();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < N; i++)
            q[i].push_back({1'b1, 8'(8'h10 + i)});
      wait_frames(16, 600, "t3 wait");
      chk_frames("t3 frame", '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12,
                               8'hA3, 8'h13, 8'hA0, 8'h10, 8'hA1, 8'h11,
                               8'hA2, 8'h12, 8'hA3, 8'h13});

      // 4) ch2 stalls mid-packet while ch0 waits
      do_reset();
      q[2].push_back({1'b0, 8'h71});
      q[2].push_back({1'b0, 8'h72});
      q[2].push_back({1'b1, 8'h73});
      wait_frames(2, 200, "t4 wait hdr");
      stall[2] = 1'b1;
      q[0].push_back({1'b1, 8'h01});
      tick();
      bad = 0;
      for (int c = 0; c < 500; c++) begin
         if (tx_valid !== 1'b0 || grant_id !== 2'd2 || busy !== 1'b1)
            bad++;
         tick();
      end
      chk("t4 stalled cycles bad", 32'(bad), 32'd0);
      chk("t4 frames during stall", 32'(frames.size()), 32'd2);
      stall[2] = 1'b0;
      wait_frames(6, 300, "t4 wait rest");
      chk_frames("t4 frame", '{8'hA2, 8'h71, 8'h72, 8'h73, 8'hA0, 8'h01});

      // 5) reset during ch1 payload; last_grant is 0 here from t4
      frames.delete();
      q[1].push_back({1'b0, 8'h51});
      q[1].push_back({1'b0, 8'h52});
      q[1].push_back({1'b1, 8'h53});
      wait_frames(2, 200, "t5 wait");
      chk("t5 pre grant", 32'(grant_id), 32'd1);
      reset = 1'b1;
      for (int i = 0; i < N; i++) q[i].delete();
      tick();
      chk("t5 rst busy", 32'(busy), 32'd0);
      chk("t5 rst tx_valid", 32'(tx_valid), 32'd0);
      chk("t5 rst tx_data", 32'(tx_data), 32'd0);
      chk("t5 rst req_ready", 32'(req_ready), 32'd0);
      chk("t5 rst grant_id", 32'(grant_id), 32'd0);
      reset = 1'b0;
      frames.delete();
      q[1].push_back({1'b1, 8'h55});
      q[0].push_back({1'b1, 8'h05});
      wait_frames(4, 300, "t5 wait after");
      chk_frames("t5 frame", '{8'hA0, 8'h05, 8'hA1, 8'h55});

      // 6) no-header instance, single byte on ch0
      r2_data = 32'h0000_005A;
      r2_valid = 4'b0001;
      r2_last = 4'b0001;
      t2_ready = 1'b1;
      chk("t6 idle ready", 32'(r2_ready), 32'd0);
      chk("t6 idle valid", 32'(t2_valid), 32'd0);
      tick();
      chk("t6 pay valid", 32'(t2_valid), 32'd1);
      chk("t6 pay data", 32'(t2_data), 32'h5A);
      chk("t6 pay ready", 32'(r2_ready), 32'b0001);
      chk("t6 pay busy", 32'(busy2), 32'd1);
      tick();
      r2_valid = '0;
      r2_last = '0;
      chk("t6 frames", 32'(frames2), 32'd1);
      chk("t6 done busy", 32'(busy2), 32'd0);
      chk("t6 done ready", 32'(r2_ready), 32'd0);
      tick();
      tick();
      chk("t6 frames final", 32'(frames2), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
